// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready-loaded parallel-to-serial shifter that feeds the d input
// of a SISO chain, paced one bit per cycle by the downstream shift_en.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             accept, step, last;
    assign accept = (state == IDLE) && load_valid;
    assign step   = (state == SHIFT) && shift_en;
    assign last   = step && (cnt == CW'(1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end
    always_comb begin
        state_nxt = accept ? SHIFT : last ? IDLE : state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            done <= last;
            if (accept) begin
                shreg <= load_data;
                cnt   <= CW'(WIDTH);
            end else if (step) begin
                shreg <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
                cnt   <= cnt - CW'(1);
            end
        end
    end
    // rst gates load_ready so nothing is offered while reset is held
    always_comb begin
        load_ready = (state == IDLE) && !rst;
        busy       = (state == SHIFT);
        sout_valid = busy;
        sout       = busy && (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
    end
endmodule
